// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM
// states, datapath mux encodings and the per-cycle control word.
package mc_pkg;

  // Supported opcodes (IR[31:26]); anything else traps.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // State encoding is visible on the debug port, so values are fixed.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Bit positions inside pcwritecond.
  localparam int PWC_BEQ = 0;
  localparam int PWC_BNE = 1;

  // Everything the datapath needs from the controller in one cycle.
  typedef struct packed {
    logic       pcwrite;
    logic [1:0] pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

  // States in which the controller waits on the memory handshake.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctl_decode.sv
// Combinational decode of the registered state into the datapath control
// word. Moore outputs, except FETCH's irwrite/pcwrite, which follow mem_ready.
module mc_ctl_decode
  import mc_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       rst_n_i,
  output ctrl_t      ctrl_o
);

  // Per-state control word; write strobes are masked while reset is held.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memread  = 1'b1;
        ctrl_o.iord     = 1'b0;
        ctrl_o.alusrca  = 1'b0;
        ctrl_o.alusrcb  = ALUSRCB_FOUR;
        ctrl_o.aluop    = ALUOP_ADD;
        ctrl_o.pcsource = PCSRC_ALU;
        ctrl_o.irwrite  = mem_ready_i;
        ctrl_o.pcwrite  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrca = 1'b0;
        ctrl_o.alusrcb = ALUSRCB_IMMSH;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regdst   = 1'b0;
      end
      S_MEMWR: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_REGB;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca  = 1'b1;
        ctrl_o.alusrcb  = ALUSRCB_REGB;
        ctrl_o.aluop    = ALUOP_SUB;
        ctrl_o.pcsource = PCSRC_ALUOUT;
        ctrl_o.pcwritecond[PWC_BEQ] = (opcode_i == OP_BEQ);
        ctrl_o.pcwritecond[PWC_BNE] = (opcode_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl_o.pcwrite  = 1'b1;
        ctrl_o.pcsource = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl_o.regdst   = 1'b0;
        ctrl_o.regwrite = 1'b1;
      end
      S_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase

    if (!rst_n_i) begin
      ctrl_o.pcwrite     = 1'b0;
      ctrl_o.pcwritecond = 2'b00;
      ctrl_o.memread     = 1'b0;
      ctrl_o.memwrite    = 1'b0;
      ctrl_o.irwrite     = 1'b0;
      ctrl_o.regwrite    = 1'b0;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: state register, next-state logic, memory
// wait timeout and retired-instruction counter. Output decode lives in
// mc_ctl_decode.
//
// Memory handshake: in FETCH/MEMRD/MEMWR the request (memread/memwrite) is
// held high every cycle until the memory returns mem_ready=1 in the same
// cycle; that cycle completes the access and the FSM advances on the next
// edge. mem_ready is ignored in every other state.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 0,
  parameter int INSTRET_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 pcwrite,
  output logic [1:0]           pcwritecond,
  output logic                 iord,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           aluop,
  output logic [1:0]           pcsource,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   timeout;
  logic                   retire;
  ctrl_t                  ctrl;

  // Timeout fires on the not-ready cycle that brings the wait count to the limit.
  always_comb begin
    timeout = 1'b0;
    if (MEM_WAIT_MAX > 0) begin
      timeout = is_mem_wait(state_q) && !mem_ready &&
                ((int'(wait_q) + 1) >= MEM_WAIT_MAX);
    end
  end

  // Next-state logic for the instruction sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDI_EX;
          default:        state_d = S_TRAP;
        endcase
      end
      // opcode is stable from DECODE, so only lw/sw can reach here.
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_TRAP;
      end
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
    if (timeout) state_d = S_TRAP;
  end

  // Wait counter and retirement bookkeeping.
  always_comb begin
    wait_d = '0;
    if (is_mem_wait(state_q) && !mem_ready && (state_d == state_q)) begin
      wait_d = wait_q + 1'b1;
    end

    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
      S_MEMWR:                                     retire = mem_ready;
      default:                                     retire = 1'b0;
    endcase
    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end

  // State, wait counter and instret registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  mc_ctl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .rst_n_i     (rst_n),
    .ctrl_o      (ctrl)
  );

  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdst      = ctrl.regdst;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign aluop       = ctrl.aluop;
  assign pcsource    = ctrl.pcsource;
  assign illegal     = ctrl.illegal;
  assign state       = state_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class cycle by cycle,
// then illegal-opcode trap, reset recovery, mid-instruction reset and the
// memory wait timeout (second instance with MEM_WAIT_MAX=4).
module tb_mc_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic [5:0] opcode    = 6'h00;
  logic       mem_ready = 1'b0;

  logic        pcwrite, iord, memread, memwrite, irwrite, memtoreg;
  logic        regdst, regwrite, alusrca, illegal;
  logic [1:0]  pcwritecond, alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic [31:0] instret;

  logic        rst_n_b     = 1'b0;
  logic        mem_ready_b = 1'b0;
  logic        pcwrite_b, iord_b, memread_b, memwrite_b, irwrite_b, memtoreg_b;
  logic        regdst_b, regwrite_b, alusrca_b, illegal_b;
  logic [1:0]  pcwritecond_b, alusrcb_b, aluop_b, pcsource_b;
  logic [3:0]  state_b;
  logic [31:0] instret_b;

  mc_control #(.MEM_WAIT_MAX(0), .INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal(illegal), .state(state), .instret(instret)
  );

  mc_control #(.MEM_WAIT_MAX(4), .INSTRET_W(32)) dut_to (
    .clk(clk), .rst_n(rst_n_b), .opcode(opcode), .mem_ready(mem_ready_b),
    .pcwrite(pcwrite_b), .pcwritecond(pcwritecond_b), .iord(iord_b),
    .memread(memread_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
    .memtoreg(memtoreg_b), .regdst(regdst_b), .regwrite(regwrite_b),
    .alusrca(alusrca_b), .alusrcb(alusrcb_b), .aluop(aluop_b),
    .pcsource(pcsource_b), .illegal(illegal_b), .state(state_b),
    .instret(instret_b)
  );

  // Observed control word, packed in a fixed order for comparison.
  logic [17:0] cw_a, cw_b;
  assign cw_a = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                 memtoreg, regdst, regwrite, alusrca, alusrcb, aluop,
                 pcsource, illegal};
  assign cw_b = {pcwrite_b, pcwritecond_b, iord_b, memread_b, memwrite_b,
                 irwrite_b, memtoreg_b, regdst_b, regwrite_b, alusrca_b,
                 alusrcb_b, aluop_b, pcsource_b, illegal_b};

  // Expected control word built from named fields, same order as cw_a.
  function automatic logic [17:0] w(
    input logic pcw, input logic [1:0] pwc, input logic io, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rd,
    input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] psrc, input logic ill);
    return {pcw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  //                                pcw pwc    io mr mw irw m2r rd rw asa asb    aop    psrc   ill
  localparam logic [17:0] W_FETCH_R  = w(1, 2'b00, 0, 1, 0, 1,  0,  0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_FETCH_NR = w(0, 2'b00, 0, 1, 0, 0,  0,  0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_FETCH_RS = w(0, 2'b00, 0, 0, 0, 0,  0,  0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_DECODE   = w(0, 2'b00, 0, 0, 0, 0,  0,  0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_MEMADR   = w(0, 2'b00, 0, 0, 0, 0,  0,  0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_MEMRD    = w(0, 2'b00, 1, 1, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_MEMRD_RS = w(0, 2'b00, 1, 0, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_MEMWB    = w(0, 2'b00, 0, 0, 0, 0,  1,  0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_MEMWR    = w(0, 2'b00, 1, 0, 1, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_EXEC     = w(0, 2'b00, 0, 0, 0, 0,  0,  0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
  localparam logic [17:0] W_RWB      = w(0, 2'b00, 0, 0, 0, 0,  0,  1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_BEQ      = w(0, 2'b01, 0, 0, 0, 0,  0,  0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
  localparam logic [17:0] W_BNE      = w(0, 2'b10, 0, 0, 0, 0,  0,  0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
  localparam logic [17:0] W_JUMP     = w(1, 2'b00, 0, 0, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
  localparam logic [17:0] W_ADDI_EX  = w(0, 2'b00, 0, 0, 0, 0,  0,  0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_ADDI_WB  = w(0, 2'b00, 0, 0, 0, 0,  0,  0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [17:0] W_TRAP     = w(0, 2'b00, 0, 0, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 1);

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle on the main DUT: drive mem_ready, check state and control
  // word mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic mr, input logic [3:0] es,
                     input logic [17:0] ew);
    mem_ready = mr;
    #1;
    check({tag, "_state"}, 32'(state), 32'(es));
    check({tag, "_ctrl"},  32'(cw_a),  32'(ew));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    opcode = 6'h00;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_state",   32'(state), 32'd0);
    check("rst_instret", instret,    32'd0);
    check("rst_ctrl",    32'(cw_a),  32'(W_FETCH_RS));
    rst_n = 1'b1;

    // lw, memory always ready: 0,1,2,3,4
    opcode = 6'h23;
    cyc("lw_fetch",  1, 4'd0, W_FETCH_R);
    cyc("lw_decode", 1, 4'd1, W_DECODE);
    cyc("lw_memadr", 1, 4'd2, W_MEMADR);
    cyc("lw_memrd",  1, 4'd3, W_MEMRD);
    cyc("lw_memwb",  1, 4'd4, W_MEMWB);
    check("lw_instret", instret, 32'd1);

    // sw with three not-ready cycles in MEMWR: 7 cycles total
    opcode = 6'h2B;
    cyc("sw_fetch",  1, 4'd0, W_FETCH_R);
    cyc("sw_decode", 1, 4'd1, W_DECODE);
    cyc("sw_memadr", 1, 4'd2, W_MEMADR);
    for (int i = 0; i < 3; i++) cyc("sw_wait", 0, 4'd5, W_MEMWR);
    check("sw_instret_hold", instret, 32'd1);
    cyc("sw_memwr",  1, 4'd5, W_MEMWR);
    check("sw_instret", instret, 32'd2);

    // beq then bne
    opcode = 6'h04;
    cyc("beq_fetch",  1, 4'd0, W_FETCH_R);
    cyc("beq_decode", 1, 4'd1, W_DECODE);
    cyc("beq_branch", 1, 4'd8, W_BEQ);
    opcode = 6'h05;
    cyc("bne_fetch",  1, 4'd0, W_FETCH_R);
    cyc("bne_decode", 1, 4'd1, W_DECODE);
    cyc("bne_branch", 0, 4'd8, W_BNE);
    check("br_instret", instret, 32'd4);

    // R-type (with one fetch stall), addi, j back-to-back
    opcode = 6'h00;
    cyc("r_fetch_stall", 0, 4'd0, W_FETCH_NR);
    cyc("r_fetch",  1, 4'd0, W_FETCH_R);
    cyc("r_decode", 0, 4'd1, W_DECODE);
    cyc("r_exec",   1, 4'd6, W_EXEC);
    cyc("r_rwb",    0, 4'd7, W_RWB);
    opcode = 6'h08;
    cyc("addi_fetch",  1, 4'd0, W_FETCH_R);
    cyc("addi_decode", 1, 4'd1, W_DECODE);
    cyc("addi_ex",     1, 4'd10, W_ADDI_EX);
    cyc("addi_wb",     1, 4'd11, W_ADDI_WB);
    opcode = 6'h02;
    cyc("j_fetch",  1, 4'd0, W_FETCH_R);
    cyc("j_decode", 1, 4'd1, W_DECODE);
    cyc("j_jump",   1, 4'd9, W_JUMP);
    check("rj_instret", instret, 32'd7);

    // illegal opcode traps at cycle 3 and stays there
    opcode = 6'h3F;
    cyc("ill_fetch",  1, 4'd0, W_FETCH_R);
    cyc("ill_decode", 1, 4'd1, W_DECODE);
    for (int i = 0; i < 20; i++)
      cyc("trap", 1'($urandom_range(0, 1)), 4'd12, W_TRAP);
    check("trap_instret", instret, 32'd7);

    // one reset edge recovers from TRAP
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("trap_rst_state",   32'(state), 32'd0);
    check("trap_rst_illegal", 32'(illegal), 32'd0);
    check("trap_rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;

    // reset mid-MEMRD: strobes drop that cycle, FETCH next
    opcode = 6'h23;
    cyc("lw2_fetch",  1, 4'd0, W_FETCH_R);
    cyc("lw2_decode", 1, 4'd1, W_DECODE);
    cyc("lw2_memadr", 1, 4'd2, W_MEMADR);
    cyc("lw2_memrd_wait", 0, 4'd3, W_MEMRD);
    rst_n = 1'b0;
    cyc("lw2_memrd_rst", 1, 4'd3, W_MEMRD_RS);
    rst_n = 1'b1;
    cyc("post_rst_fetch", 0, 4'd0, W_FETCH_NR);
    check("post_rst_instret", instret, 32'd0);

    // wait timeout on the MEM_WAIT_MAX=4 instance: four FETCH waits then TRAP
    rst_n_b = 1'b1;
    mem_ready_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_wait_state", 32'(state_b), 32'd0);
      check("to_wait_ctrl",  32'(cw_b),    32'(W_FETCH_NR));
      @(posedge clk);
      #1;
    end
    #1;
    check("to_trap_state", 32'(state_b), 32'd12);
    check("to_trap_ctrl",  32'(cw_b),    32'(W_TRAP));
    check("to_instret",    instret_b,    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control FSM for the MIPS datapath.
- Sequences one instruction over 3–5 cycles through shared memory, ALU and register file, driving the datapath mux selects and write strobes each cycle.
- Stalls on a memory ready handshake and traps on unsupported opcodes.
- Sits beside the multicycle datapath and takes opcode from the instruction register output.

Parameters:
- MEM_WAIT_MAX, 0, upper bound on mem_ready wait cycles; 0 = unbounded, otherwise exceeding it enters TRAP.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until instruction completes
- mem_ready  in  1  memory completes current read/write this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  2  bit0 = write PC if zero (beq); bit1 = write PC if not zero (bne)
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  1  IR load
- memtoreg  out  1  register write data: 1 = MDR, 0 = ALUOut
- regdst  out  1  destination register: 1 = rd, 0 = rt
- regwrite  out  1  register file write
- alusrca  out  1  ALU A input: 0 = PC, 1 = regA
- alusrcb  out  2  ALU B input: 00 = regB, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pcsource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  out  1  sticky trap indicator
- state  out  4  current state encoding, for debug
- instret  out  INSTRET_W  retired instruction count

Behaviour:
- Opcodes: R-type 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, lw 0x23, sw 0x2B. Every other opcode is illegal.
- States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12.
- Outputs are decoded combinationally from the registered state (Moore). The only exceptions are the mem_ready-gated strobes noted below.
- Any output not listed for a state is 0.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite = mem_ready.
  - mem_ready=1 → DECODE; otherwise hold in FETCH.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
  - Next state: lw/sw → MEMADR; R-type → EXEC; beq/bne → BRANCH; j → JUMP; addi → ADDI_EX; otherwise → TRAP.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw → MEMRD; sw → MEMWR.
- MEMRD: memread=1, iord=1. mem_ready → MEMWB; otherwise hold.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 → FETCH.
- MEMWR: memwrite=1, iord=1. mem_ready → FETCH; otherwise hold. memwrite stays asserted every wait cycle.
- EXEC: alusrca=1, alusrcb=00, aluop=10 → RWB.
- RWB: regdst=1, regwrite=1 → FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcsource=01.
  - pcwritecond=01 for beq, 10 for bne → FETCH.
- JUMP: pcwrite=1, pcsource=10 → FETCH.
- ADDI_EX: alusrca=1, alusrcb=10, aluop=00 → ADDI_WB.
- ADDI_WB: regdst=0, regwrite=1 → FETCH.
- TRAP: illegal=1, all strobes 0. Stays until reset.
- Latency (mem_ready immediate): j and beq/bne 3 cycles; R-type and addi 4; sw 4; lw 5. Each mem wait cycle adds 1.
- instret increments by 1 on the final cycle of each instruction: the transition into FETCH from MEMWB, MEMWR(+mem_ready), RWB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^INSTRET_W.
- Wait timeout: if MEM_WAIT_MAX>0, a counter tracks consecutive not-ready cycles in FETCH/MEMRD/MEMWR. Reaching MEM_WAIT_MAX → TRAP on the next edge. The counter clears on any state change.
- Reset (rst_n=0 at an edge): state=FETCH, instret=0, illegal=0, wait counter=0.
  - While rst_n=0, all strobes (pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite) are forced 0 combinationally. Mux selects follow state.
  - Reset mid-instruction or in TRAP aborts immediately; the first post-reset cycle is FETCH.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Decomposition:
- Package mc_pkg holds:
  - opcode constants;
  - state encodings;
  - ALUOP_ADD/SUB/FUNCT;
  - ALUSRCB_* and PCSRC_* encodings;
  - PWC_BEQ=bit0 and PWC_BNE=bit1.
- One sub-module mc_ctl_decode: pure combinational state + opcode + mem_ready + rst_n → control word.
- The top level holds the state register, next-state logic, wait counter and instret.

Test Plan:
- Reset then lw (0x23), mem_ready always 1 → states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. instret=1 after.
- sw (0x2B) with mem_ready low 3 cycles in MEMWR → memwrite=1 for 4 cycles, iord=1, then FETCH. Latency 7. instret +1.
- beq (0x04) then bne (0x05) → BRANCH cycle shows pcwritecond=01 then 10, aluop=01, pcsource=01. 3 cycles each.
- R-type (0x00), addi (0x08), j (0x02) back-to-back → regdst 1/0 in RWB/ADDI_WB, JUMP pcsource=10 with pcwrite=1. instret=3.
- Opcode 0x3F → TRAP at cycle 3, illegal=1, no strobes for 20 cycles. rst_n=0 one edge → FETCH, illegal=0, instret=0.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH → TRAP after 4 wait cycles. Separately, rst_n=0 mid-MEMRD → all strobes 0 that cycle, FETCH next.
